helper_data_generator: RTL and testbench
========================================

// Module: helper_data_generator
// PURPOSE
//  Enrollment-side counterpart of the PUF signature/ECC decode path.
//  - On start, reads NO_ROUND words from the PUF SRAM beginning at challenge address addr.
//  - Assembles the SIGN_SIZE-bit signature from those words.
//  - Computes the 96-bit helper data that the decode path later consumes as i_helper.
//  - Sits between the PUF SRAM read port and the enrollment/NVM controller.
// PARAMETERS
//  CHALLENGE_SIZE     32   SRAM address width (challenge)
//  SIGN_SIZE          256  signature width; must equal NO_ROUND*MEM_SIZE_PER_ADDR
//  HELPER_DATA_SIZE   96   helper width; the format below fixes it at 96
//  MEM_SIZE_PER_ADDR  8    SRAM word width
//  NO_ROUND (localparam) = SIGN_SIZE/MEM_SIZE_PER_ADDR = 32
//  Only the defaults are supported. Elaboration $error on any other combination.
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    synchronous, active-low reset
//  start      in   1                    1-cycle request; sampled only in IDLE
//  addr       in   CHALLENGE_SIZE       start address; latched when start is accepted
//  sram_addr  out  CHALLENGE_SIZE       SRAM read address
//  sram_re    out  1                    SRAM read enable
//  sram_q     in   MEM_SIZE_PER_ADDR    SRAM data; valid exactly 1 cycle after sram_re
//  busy       out  1                    high from the cycle after start is accepted until done
//  done       out  1                    1-cycle pulse; outputs valid
//  puf_signature  out  SIGN_SIZE        assembled signature
//  o_helper   out  [0:HELPER_DATA_SIZE-1]  helper data, MSB-first indexing
// BEHAVIOUR
//  Reset (rst==0 at posedge) forces the following, regardless of state:
//  - FSM goes to IDLE.
//  - sram_re=0, sram_addr=0, busy=0, done=0, puf_signature=0, o_helper=0.
//  - CRC state = 32'hFFFFFFFF.
//  FSM states:
//  - IDLE:
//    - start=1 latches addr, clears the accumulators, and moves to READ.
//  - READ (NO_ROUND cycles):
//    - sram_re=1, sram_addr = addr+i for i=0..31.
//    - Addresses wrap modulo 2^CHALLENGE_SIZE (e.g. FFFFFFFF -> 00000000).
//  - DRAIN (1 cycle):
//    - sram_re=0; captures the last word.
//  - DONE (1 cycle):
//    - done=1, busy=0; then returns to IDLE.
//  Capture:
//  - The word read for index i arrives on sram_q the cycle after issue.
//  - Capture shifts left: sig <= {sig[SIGN_SIZE-9:0], sram_q}.
//  - Word 0 therefore ends in sig[255:248].
//  Timing:
//  - Latency from the start-accept edge to the done cycle is NO_ROUND+2 = 34 cycles.
//  - busy is high for 33 cycles.
//  Helper format, accumulated per captured byte b_k (k = read order 0..31):
//  - o_helper[0:31] : bit k = ^b_k (byte parity).
//  - o_helper[32:63]: XOR of the eight 32-bit signature words (sig[255:224] ^ ... ^ sig[31:0]).
//  - o_helper[64:95]: CRC-32.
//    - Poly 04C11DB7, init FFFFFFFF.
//    - Bytes processed in read order, MSB-first, no reflection, no final XOR.
//  Output holding and side conditions:
//  - puf_signature and o_helper keep their final value after done until the next accepted start.
//  - Intermediate values while busy are don't-care.
//  - start is ignored while busy or in DONE; no queuing.
//  - start and done in the same cycle: start is ignored.
//  - sram_q is ignored whenever no read is outstanding.
//  - Reset in any state aborts the operation immediately; no done pulse follows.
// TESTING
//  1. SRAM byte at a+k = k, addr=0:
//     - puf_signature = 256'h000102...1E1F.
//     - o_helper[0:31] = 32'h69969669.
//     - o_helper[32:63] = 0.
//     - CRC must match the bench model.
//     - done exactly 34 cycles after start.
//  2. All bytes 8'hFF:
//     - signature all ones.
//     - o_helper[0:31] = 0.
//     - o_helper[32:63] = 0.
//     - CRC must match the model.
//  3. addr=32'hFFFFFFF0:
//     - sram_addr sequence FFFFFFF0..FFFFFFFF, then 00000000..0000000F.
//     - sram_re high for exactly 32 cycles.
//  4. start pulsed again at cycle 10 of an operation:
//     - Ignored: same outputs, one done pulse.
//     - A second start after done starts a new run with the accumulators cleared.
//  5. rst=0 at cycle 15 of an operation:
//     - Next cycle: all outputs zero, IDLE, no done.
//     - A fresh start then completes normally.
//  6. Random SRAM contents, 200 runs with random addr:
//     - signature and helper match the reference model.
//     - Helper fed to the decode path reproduces the signature.

Source files
------------

// File: rtl/helper_data_generator.sv
// helper_data_generator
//   Enrollment-side helper-data builder for the PUF. A start request reads
//   NO_ROUND consecutive SRAM words from the challenge address and assembles
//   them into the signature. While it reads, it builds the 96-bit helper data:
//   byte parities, the XOR of the 32-bit signature words, and a CRC-32.
//
//   Ports
//     clk, rst           clock, synchronous active-low reset
//     start, addr        one-cycle request and challenge address (IDLE only)
//     sram_addr, sram_re SRAM read request
//     sram_q             SRAM read data, valid one cycle after sram_re
//     busy, done         operation in flight / one-cycle completion pulse
//     puf_signature      assembled signature, held until the next start
//     o_helper           helper data [0:95] = {parity, word xor, crc}
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start
//   READ   | issuing NO_ROUND reads, capturing the word from the prior cycle
//   DRAIN  | no read issued; captures the last word and latches the helper
//   DONE   | done pulse, outputs valid
module helper_data_generator #(
  parameter int CHALLENGE_SIZE    = 32,
  parameter int SIGN_SIZE         = 256,
  parameter int HELPER_DATA_SIZE  = 96,
  parameter int MEM_SIZE_PER_ADDR = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CHALLENGE_SIZE-1:0]      addr,
  output logic [CHALLENGE_SIZE-1:0]      sram_addr,
  output logic                           sram_re,
  input  logic [MEM_SIZE_PER_ADDR-1:0]   sram_q,
  output logic                           busy,
  output logic                           done,
  output logic [SIGN_SIZE-1:0]           puf_signature,
  output logic [0:HELPER_DATA_SIZE-1]    o_helper
);

  localparam int NO_ROUND = SIGN_SIZE / MEM_SIZE_PER_ADDR;
  localparam int CNT_W    = $clog2(NO_ROUND);
  localparam int N_WORDS  = SIGN_SIZE / 32;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  if (CHALLENGE_SIZE != 32 || SIGN_SIZE != 256 || HELPER_DATA_SIZE != 96 ||
      MEM_SIZE_PER_ADDR != 8) begin : g_param_check
    $error("helper_data_generator: only the default parameter set is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CHALLENGE_SIZE-1:0]     addr_q, addr_d;
  logic                          re_q, re_d;
  logic                          rd_vld_q, rd_vld_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [SIGN_SIZE-1:0]          sig_q, sig_d;
  logic [NO_ROUND-1:0]           par_q, par_d;
  logic [31:0]                   crc_q, crc_d;
  logic [HELPER_DATA_SIZE-1:0]   helper_q, helper_d;

  // One CRC-32 byte step, MSB-first, non-reflected.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [MEM_SIZE_PER_ADDR-1:0] b);
    logic [31:0] c;
    c = crc_in ^ {b, {(32-MEM_SIZE_PER_ADDR){1'b0}}};
    for (int i = 0; i < MEM_SIZE_PER_ADDR; i++) begin
      c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] word_xor(input logic [SIGN_SIZE-1:0] s);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      x = x ^ s[i*32 +: 32];
    end
    return x;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    re_d     = re_q;
    rd_vld_d = re_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sig_d    = sig_q;
    par_d    = par_q;
    crc_d    = crc_q;
    helper_d = helper_q;

    // rd_vld_q marks the cycle where the word requested last cycle is on sram_q.
    if (rd_vld_q) begin
      sig_d = {sig_q[SIGN_SIZE-MEM_SIZE_PER_ADDR-1:0], sram_q};
      par_d = {par_q[NO_ROUND-2:0], ^sram_q};
      crc_d = crc_byte(crc_q, sram_q);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = addr;
          re_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(NO_ROUND - 1);
          sig_d   = '0;
          par_d   = '0;
          crc_d   = CRC_INIT;
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          re_d    = 1'b0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          addr_d = addr_q + CHALLENGE_SIZE'(1);
        end
      end
      S_DRAIN: begin
        // Helper is latched from the post-capture values so it is valid with done.
        state_d  = S_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        helper_d = {par_d, word_xor(sig_d), crc_d};
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= '0;
      par_q    <= '0;
      crc_q    <= CRC_INIT;
      helper_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      rd_vld_q <= rd_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sig_q    <= sig_d;
      par_q    <= par_d;
      crc_q    <= crc_d;
      helper_q <= helper_d;
    end
  end

  assign sram_addr     = addr_q;
  assign sram_re       = re_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign puf_signature = sig_q;
  assign o_helper      = helper_q;

endmodule

// File: tb/tb_helper_data_generator.sv
module tb_helper_data_generator;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   addr;
  logic [31:0]   sram_addr;
  logic          sram_re;
  logic [7:0]    sram_q;
  logic          busy;
  logic          done;
  logic [255:0]  puf_signature;
  logic [0:95]   o_helper;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  localparam logic [255:0] SIG_RAMP =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

  helper_data_generator dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .addr          (addr),
    .sram_addr     (sram_addr),
    .sram_re       (sram_re),
    .sram_q        (sram_q),
    .busy          (busy),
    .done          (done),
    .puf_signature (puf_signature),
    .o_helper      (o_helper)
  );

  always #5 clk = ~clk;

  // SRAM: data one cycle after the read, garbage otherwise.
  always @(posedge clk) begin
    if (sram_re) sram_q <= mem[sram_addr[7:0]];
    else         sram_q <= 8'($urandom);
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pattern: 0 ramp relative to base, 1 all FF, 2 all 00, 3 all 01,
  //          4 single 80 at base, 5 random
  task automatic fill(input int pat, input logic [31:0] a);
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0: mem[i] = 8'(i) - a[7:0];
        1: mem[i] = 8'hFF;
        2: mem[i] = 8'h00;
        3: mem[i] = 8'h01;
        4: mem[i] = (8'(i) == a[7:0]) ? 8'h80 : 8'h00;
        default: mem[i] = 8'($urandom);
      endcase
    end
  endtask

  // Reference: signature is the bytes in read order; parity bit k is MSB-first;
  // word XOR accumulates each byte into its lane; CRC is bit-serial.
  function automatic void model(input logic [31:0] a, output logic [255:0] s,
                                output logic [95:0] h);
    logic [7:0]  b;
    logic [31:0] par = '0;
    logic [31:0] xw  = '0;
    logic [31:0] crc = 32'hFFFFFFFF;
    logic        fb;
    s = '0;
    for (int k = 0; k < 32; k++) begin
      b = mem[8'(a + 32'(k))];
      s[255 - 8*k -: 8] = b;
      par[31 - k] = ^b;
      xw[31 - 8*(k % 4) -: 8] = xw[31 - 8*(k % 4) -: 8] ^ b;
      for (int j = 7; j >= 0; j--) begin
        fb  = crc[31] ^ b[j];
        crc = {crc[30:0], 1'b0};
        if (fb) crc = crc ^ 32'h04C11DB7;
      end
    end
    h = {par, xw, crc};
  endfunction

  // Starts an operation and returns on the done cycle (or on abort / timeout).
  task automatic run_op(input logic [31:0] a, input int restart_at, input int abort_at,
                        output int lat, output int busy_cnt, output int re_cnt,
                        output int addr_err, output int done_cnt);
    lat = 0; busy_cnt = 0; re_cnt = 0; addr_err = 0; done_cnt = 0;
    @(negedge clk);
    addr  = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr  = $urandom;
    lat   = 1;
    while (lat < 60) begin
      if (lat == abort_at) begin
        rst = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      if (sram_re) begin
        if (sram_addr !== a + 32'(re_cnt)) addr_err++;
        re_cnt++;
      end
      if (done) begin
        done_cnt++;
        break;
      end
      start = (lat == restart_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  typedef struct {
    logic [31:0]  a;
    int           pat;
    logic [255:0] sig;
    logic [31:0]  par;
    logic [31:0]  xw;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [255:0] es;
    logic [95:0]  eh;
    int lat, bc, rc, ae, dc, n;

    vecs[0] = '{32'h0000_0000, 0, SIG_RAMP,        32'h69969669, 32'h0};
    vecs[1] = '{32'h1234_5678, 1, {256{1'b1}},     32'h0,        32'h0};
    vecs[2] = '{32'hFFFF_FFF0, 0, SIG_RAMP,        32'h69969669, 32'h0};
    vecs[3] = '{32'h0000_0055, 2, 256'h0,          32'h0,        32'h0};
    vecs[4] = '{32'h0000_00A0, 3, {32{8'h01}},     32'hFFFFFFFF, 32'h0};
    vecs[5] = '{32'h0000_007F, 4, {8'h80, 248'h0}, 32'h80000000, 32'h80000000};

    rst = 1'b0; start = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_re",   256'(sram_re), 256'd0);
    chk("reset_addr", 256'(sram_addr), 256'd0);
    chk("reset_sig",  puf_signature, 256'd0);
    chk("reset_help", 256'(o_helper), 256'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      fill(vecs[v].pat, vecs[v].a);
      model(vecs[v].a, es, eh);
      run_op(vecs[v].a, -1, -1, lat, bc, rc, ae, dc);
      chk("vec_latency", 256'(lat), 256'd34);
      chk("vec_busy_cycles", 256'(bc), 256'd33);
      chk("vec_re_cycles", 256'(rc), 256'd32);
      chk("vec_addr_seq", 256'(ae), 256'd0);
      chk("vec_sig", puf_signature, vecs[v].sig);
      chk("vec_parity", 256'(o_helper[0:31]), 256'(vecs[v].par));
      chk("vec_wordxor", 256'(o_helper[32:63]), 256'(vecs[v].xw));
      chk("vec_crc", 256'(o_helper[64:95]), 256'(eh[31:0]));
      count_done(3, n);
      chk("vec_single_done", 256'(n), 256'd0);
      chk("vec_hold_sig", puf_signature, vecs[v].sig);
      chk("vec_hold_help", 256'(o_helper), 256'(eh));
    end

    // Start during an operation is ignored; no second run is queued.
    fill(0, 32'h40);
    model(32'h40, es, eh);
    run_op(32'h40, 10, -1, lat, bc, rc, ae, dc);
    chk("restart_latency", 256'(lat), 256'd34);
    chk("restart_sig", puf_signature, SIG_RAMP);
    chk("restart_help", 256'(o_helper), 256'(eh));
    count_done(40, n);
    chk("restart_no_extra_done", 256'(n), 256'd0);
    // New run afterwards starts from cleared accumulators.
    fill(1, 32'h40);
    model(32'h40, es, eh);
    run_op(32'h40, -1, -1, lat, bc, rc, ae, dc);
    chk("rerun_sig", puf_signature, {256{1'b1}});
    chk("rerun_help", 256'(o_helper), 256'(eh));

    // Start coinciding with done is ignored.
    fill(5, 32'h0);
    run_op(32'h1000, -1, -1, lat, bc, rc, ae, dc);
    start = 1'b1;
    addr  = 32'h2000;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", 256'(busy), 256'd0);
    chk("start_at_done_re", 256'(sram_re), 256'd0);

    // Reset mid-operation aborts with no done.
    fill(0, 32'h10);
    run_op(32'h10, -1, 15, lat, bc, rc, ae, dc);
    @(negedge clk);
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_re", 256'(sram_re), 256'd0);
    chk("abort_addr", 256'(sram_addr), 256'd0);
    chk("abort_sig", puf_signature, 256'd0);
    chk("abort_help", 256'(o_helper), 256'd0);
    chk("abort_done", 256'(done), 256'd0);
    rst = 1'b1;
    count_done(40, n);
    chk("abort_no_done", 256'(n), 256'd0);
    model(32'h10, es, eh);
    run_op(32'h10, -1, -1, lat, bc, rc, ae, dc);
    chk("after_abort_latency", 256'(lat), 256'd34);
    chk("after_abort_sig", puf_signature, SIG_RAMP);
    chk("after_abort_help", 256'(o_helper), 256'(eh));

    // Random contents and addresses.
    for (int r = 0; r < 200; r++) begin
      logic [31:0] a;
      a = $urandom;
      fill(5, a);
      model(a, es, eh);
      run_op(a, -1, -1, lat, bc, rc, ae, dc);
      chk("rand_latency", 256'(lat), 256'd34);
      chk("rand_addr_seq", 256'(ae), 256'd0);
      chk("rand_sig", puf_signature, es);
      chk("rand_help", 256'(o_helper), 256'(eh));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
